// File: rtl/ps2_game_cmd_decoder.sv
// PS/2 set-2 command decoder: byte parser, arrow hold/step tracking with
// auto-repeat, and END/PLAY/PAUSE game-mode FSM gating all movement.
module ps2_game_cmd_decoder #(
    parameter int         REPEAT_DELAY        = 25_000_000,
    parameter int         REPEAT_PERIOD       = 5_000_000,
    parameter bit         ALLOW_KEYPAD_ARROWS = 1'b1,
    parameter logic [7:0] CODE_LEFT           = 8'h6B,
    parameter logic [7:0] CODE_RIGHT          = 8'h74,
    parameter logic [7:0] CODE_ENTER          = 8'h5A,
    parameter logic [7:0] CODE_ESC            = 8'h76,
    parameter logic [7:0] CODE_PAUSE          = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] game_state,
    output logic       end_game,
    output logic       idle_game,
    output logic       left_held,
    output logic       right_held,
    output logic       left_step,
    output logic       right_step
);

    localparam logic [1:0] P_BASE    = 2'd0;
    localparam logic [1:0] P_EXT     = 2'd1;
    localparam logic [1:0] P_BRK     = 2'd2;
    localparam logic [1:0] P_EXT_BRK = 2'd3;

    localparam logic [1:0] G_END   = 2'b00;
    localparam logic [1:0] G_PLAY  = 2'b01;
    localparam logic [1:0] G_PAUSE = 2'b10;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    localparam int MAXR = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = (MAXR > 1) ? $clog2(MAXR) : 1;

    localparam logic [CW-1:0] DLY_LD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LD = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    r_pstate;
    logic [1:0]    r_gstate;
    logic          r_end;
    logic          r_idle;
    logic          r_lheld;
    logic          r_rheld;
    logic          r_lstep;
    logic          r_rstep;
    logic          r_last;
    logic [CW-1:0] r_lcnt;
    logic [CW-1:0] r_rcnt;

    logic [1:0]    w_pnxt;
    logic          w_evt;
    logic          w_ext;
    logic          w_brk;
    logic          w_discard;
    logic          w_is_e0;
    logic          w_is_f0;
    logic          w_mk;
    logic          w_bk;
    logic          w_code_l;
    logic          w_code_r;
    logic          w_l_mk;
    logic          w_l_bk;
    logic          w_r_mk;
    logic          w_r_bk;
    logic          w_l_new;
    logic          w_r_new;
    logic          w_enter;
    logic          w_esc;
    logic          w_pause;
    logic [1:0]    w_gnxt;
    logic          w_play_ok;
    logic          w_l_active;
    logic          w_r_active;
    logic          w_lheld_n;
    logic          w_rheld_n;
    logic          w_lstep_n;
    logic          w_rstep_n;
    logic [CW-1:0] w_lcnt_n;
    logic [CW-1:0] w_rcnt_n;
    logic          w_last_n;

    assign w_ext     = (r_pstate == P_EXT) || (r_pstate == P_EXT_BRK);
    assign w_brk     = (r_pstate == P_BRK) || (r_pstate == P_EXT_BRK);
    assign w_is_e0   = (rx_data == 8'hE0);
    assign w_is_f0   = (rx_data == 8'hF0);
    assign w_discard = (rx_data == 8'hE1) || (rx_data == 8'hFA) ||
                       (rx_data == 8'hAA) || (rx_data == 8'hFE) ||
                       (rx_data == 8'hEE);

    // Parser next state; any non-prefix byte completes one key event
    always_comb begin
        w_pnxt = r_pstate;
        w_evt  = 1'b0;
        if (rx_valid) begin
            unique case (1'b1)
                w_discard: w_pnxt = P_BASE;
                w_is_e0:   w_pnxt = P_EXT;
                w_is_f0: begin
                    if (r_pstate == P_BASE)
                        w_pnxt = P_BRK;
                    else if (r_pstate == P_EXT)
                        w_pnxt = P_EXT_BRK;
                end
                default: begin
                    w_evt  = 1'b1;
                    w_pnxt = P_BASE;
                end
            endcase
        end
    end

    assign w_mk     = w_evt && !w_brk;
    assign w_bk     = w_evt && w_brk;
    assign w_code_l = (rx_data == CODE_LEFT) &&
                      (w_ext || ALLOW_KEYPAD_ARROWS);
    assign w_code_r = (rx_data == CODE_RIGHT) &&
                      (w_ext || ALLOW_KEYPAD_ARROWS);
    assign w_l_mk   = w_mk && w_code_l;
    assign w_l_bk   = w_bk && w_code_l;
    assign w_r_mk   = w_mk && w_code_r;
    assign w_r_bk   = w_bk && w_code_r;
    assign w_enter  = w_mk && !w_ext && (rx_data == CODE_ENTER);
    assign w_esc    = w_mk && !w_ext && (rx_data == CODE_ESC);
    assign w_pause  = w_mk && !w_ext && (rx_data == CODE_PAUSE);
    assign w_l_new  = w_l_mk && !r_lheld;
    assign w_r_new  = w_r_mk && !r_rheld;

    // Game-mode transitions, driven by make events only
    always_comb begin
        w_gnxt = r_gstate;
        case (r_gstate)
            G_END: begin
                if (w_enter)
                    w_gnxt = G_PLAY;
            end
            G_PLAY: begin
                if (w_esc)
                    w_gnxt = G_END;
                else if (w_pause)
                    w_gnxt = G_PAUSE;
            end
            G_PAUSE: begin
                if (w_pause)
                    w_gnxt = G_PLAY;
                else if (w_esc)
                    w_gnxt = G_END;
            end
            default: w_gnxt = G_END;
        endcase
    end

    // Movement only counts while PLAY is both current and kept this cycle
    assign w_play_ok  = (r_gstate == G_PLAY) && (w_gnxt == G_PLAY);
    assign w_l_active = r_lheld && (!r_rheld || r_last == DIR_L) && !w_r_new;
    assign w_r_active = r_rheld && (!r_lheld || r_last == DIR_R) && !w_l_new;

    // Left hold flag, repeat counter and step pulse
    always_comb begin
        w_lheld_n = r_lheld;
        w_lcnt_n  = r_lcnt;
        w_lstep_n = 1'b0;
        if (!w_play_ok) begin
            w_lheld_n = 1'b0;
            w_lcnt_n  = '0;
        end else if (w_l_bk) begin
            w_lheld_n = 1'b0;
            w_lcnt_n  = '0;
        end else if (w_l_new) begin
            w_lheld_n = 1'b1;
            w_lstep_n = 1'b1;
            w_lcnt_n  = DLY_LD;
        end else if (w_r_bk && r_rheld && r_lheld && r_last == DIR_R) begin
            w_lcnt_n  = DLY_LD;
        end else if (w_l_active) begin
            if (r_lcnt == '0) begin
                w_lstep_n = 1'b1;
                w_lcnt_n  = PER_LD;
            end else begin
                w_lcnt_n  = r_lcnt - 1'b1;
            end
        end
    end

    // Right hold flag, repeat counter and step pulse
    always_comb begin
        w_rheld_n = r_rheld;
        w_rcnt_n  = r_rcnt;
        w_rstep_n = 1'b0;
        if (!w_play_ok) begin
            w_rheld_n = 1'b0;
            w_rcnt_n  = '0;
        end else if (w_r_bk) begin
            w_rheld_n = 1'b0;
            w_rcnt_n  = '0;
        end else if (w_r_new) begin
            w_rheld_n = 1'b1;
            w_rstep_n = 1'b1;
            w_rcnt_n  = DLY_LD;
        end else if (w_l_bk && r_lheld && r_rheld && r_last == DIR_L) begin
            w_rcnt_n  = DLY_LD;
        end else if (w_r_active) begin
            if (r_rcnt == '0) begin
                w_rstep_n = 1'b1;
                w_rcnt_n  = PER_LD;
            end else begin
                w_rcnt_n  = r_rcnt - 1'b1;
            end
        end
    end

    // Most recently pressed direction owns the stepping
    always_comb begin
        w_last_n = r_last;
        if (w_play_ok && w_l_new)
            w_last_n = DIR_L;
        else if (w_play_ok && w_r_new)
            w_last_n = DIR_R;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pstate <= P_BASE;
            r_gstate <= G_END;
            r_end    <= 1'b1;
            r_idle   <= 1'b0;
            r_lheld  <= 1'b0;
            r_rheld  <= 1'b0;
            r_lstep  <= 1'b0;
            r_rstep  <= 1'b0;
            r_last   <= DIR_L;
            r_lcnt   <= '0;
            r_rcnt   <= '0;
        end else begin
            r_pstate <= w_pnxt;
            r_gstate <= w_gnxt;
            r_end    <= (w_gnxt == G_END);
            r_idle   <= (w_gnxt == G_PLAY) && !w_lheld_n && !w_rheld_n;
            r_lheld  <= w_lheld_n;
            r_rheld  <= w_rheld_n;
            r_lstep  <= w_lstep_n;
            r_rstep  <= w_rstep_n;
            r_last   <= w_last_n;
            r_lcnt   <= w_lcnt_n;
            r_rcnt   <= w_rcnt_n;
        end
    end

    assign game_state = r_gstate;
    assign end_game   = r_end;
    assign idle_game  = r_idle;
    assign left_held  = r_lheld;
    assign right_held = r_rheld;
    assign left_step  = r_lstep;
    assign right_step = r_rstep;

endmodule

// File: doc/ps2_game_cmd_decoder.md
# ps2_game_cmd_decoder

Parametrised PS/2 command decoder between the `PS2_Controller` byte stream and the game logic. It parses full set-2 make/break sequences, including the `E0` extended and `F0` break prefixes, and tracks which arrow keys are held. From those it produces single-cycle left/right step pulses with a programmable auto-repeat. It also runs a three-state game-mode FSM (END / PLAY / PAUSE) that gates all movement output.

## Interface
Parameters:
- `REPEAT_DELAY`, default 25_000_000: cycles from the initial step pulse to the first auto-repeat pulse. Minimum 2.
- `REPEAT_PERIOD`, default 5_000_000: cycles between auto-repeat pulses. Minimum 2.
- `ALLOW_KEYPAD_ARROWS`, default 1: when 1, non-extended `6B`/`74` (keypad 4/6) also count as left/right.
- `CODE_LEFT`, default 8'h6B; `CODE_RIGHT`, default 8'h74; `CODE_ENTER`, default 8'h5A; `CODE_ESC`, default 8'h76; `CODE_PAUSE`, default 8'h29 (space).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: byte from `PS2_Controller.received_data`.
- `rx_valid` in 1: single-cycle strobe from `received_data_en`.
- `game_state` out 2: 2'b00 END, 2'b01 PLAY, 2'b10 PAUSE.
- `end_game` out 1: `game_state`==END.
- `idle_game` out 1: PLAY with neither arrow held.
- `left_held`, `right_held` out 1 each: key currently held (PLAY only).
- `left_step`, `right_step` out 1 each: single-cycle movement pulses.

## Operation
Byte parser FSM: states `P_BASE`, `P_EXT`, `P_BRK`, `P_EXT_BRK`.
- `E0` in `P_BASE` -> `P_EXT`.
- `F0` in `P_BASE` -> `P_BRK`.
- `F0` in `P_EXT` -> `P_EXT_BRK`.
- Any other byte completes an event {code, ext, brk} and returns the parser to `P_BASE`.
- `E0` in any non-base state restarts at `P_EXT`. `F0` in `P_BRK` or `P_EXT_BRK` is ignored; the state is held.
- Bytes `E1`, `FA`, `AA`, `FE`, `EE` in any state are discarded and the parser returns to `P_BASE`.

Key decode:
- Left = `CODE_LEFT` with ext=1, or ext=0 if `ALLOW_KEYPAD_ARROWS`. Right decodes the same way.
- Enter, Esc and Pause match only with ext=0.

Game FSM (acts on make events only; break events never change the mode):
- END: Enter -> PLAY.
- PLAY: Esc -> END; Pause -> PAUSE.
- PAUSE: Pause -> PLAY; Esc -> END.
- Leaving PLAY clears both held flags and both repeat counters.
- Arrow events outside PLAY are ignored, so a key already held at PAUSE->PLAY produces nothing until it is pressed again.

Held and step logic, per direction:
- Make while not held: set held, pulse step, load the counter with `REPEAT_DELAY-1`.
- Make while already held (PS/2 typematic repeat): ignored.
- Break: clear held; no pulse.
- While held in PLAY, the counter decrements each cycle. At 0 it pulses step and reloads `REPEAT_PERIOD-1`.
- Both held: only the most recently pressed direction steps. The other's counter is frozen. When the newer key is released, the older direction resumes with a fresh `REPEAT_DELAY` and no immediate pulse.
- `left_step` and `right_step` are never high together.
- Counter width is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))`.

## Timing
- All outputs are registered.
- Reset values: `game_state`=END, `end_game`=1, `idle_game`=0, held=0, step=0, parser `P_BASE`, counters 0.
- Latency: for the final byte of a sequence, `rx_valid` high in cycle N gives the step pulse and updated `game_state` / held flags in cycle N+1.
- Repeat: the first auto pulse comes `REPEAT_DELAY` cycles after the initial pulse, then one every `REPEAT_PERIOD` cycles.
- Counter expiry in the same cycle as a break for that direction: the break wins and no pulse is issued.
- Counter expiry in the same cycle as an Esc/Pause make: the mode change wins and no pulse is issued.
- `reset` mid-sequence, e.g. after `E0` or `F0`: the parser returns to `P_BASE` and the partial sequence is dropped.
- `rx_valid` may assert on consecutive cycles; every byte is consumed.

## Test plan
Use `REPEAT_DELAY`=8 and `REPEAT_PERIOD`=4 unless stated.
- Reset, then `5A`: `game_state` 00->01 one cycle after `rx_valid`; `end_game` 1->0; `idle_game`=1.
- In PLAY, send `E0 6B` and hold 20 cycles, then `E0 F0 6B`:
  - `left_step` pulses at +1, +9, +13, +17 after the `6B` byte.
  - `left_held` is 1 during the hold and falls one cycle after the final `6B`.
  - No pulse accompanies the break.
- In PLAY, send `E0 74` and then `E0 74` again 3 cycles later (typematic): exactly one `right_step` pulse before cycle +9.
- In PLAY, hold left, then press `E0 74`:
  - Right steps; left stays silent.
  - Release right: the next `left_step` comes exactly 8 cycles later.
- In PLAY with left held, send `29`:
  - `game_state`=10, `left_held`=0, no further steps.
  - Send `E0 6B`: no step.
  - Send `29`: PLAY, `idle_game`=1.
- Send `E0`, then assert `reset`, then send `6B` with `ALLOW_KEYPAD_ARROWS`=0: the state is END and no held flag or step is produced. Separately, `F0 76` while in PLAY leaves the mode unchanged.
